// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: opcode and controller state encodings.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } alu_state_e;

    // ADD and SUB use the carry chain; AND/OR never produce carry or overflow.
    function automatic logic is_arith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice. SUB arrives here as an ADD with b already inverted
// and the carry seeded to 1 by the caller, so both share the full adder.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] s_op,
    output logic       z,
    output logic       cout
);

    // Select the slice function; carry-out only exists for the adder ops.
    always_comb begin
        z    = 1'b0;
        cout = 1'b0;
        case (alu_op_e'(s_op))
            OP_AND: z = a & b;
            OP_OR:  z = a | b;
            OP_ADD, OP_SUB: begin
                z    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            default: begin
                z    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU. Operands are consumed LSB first through a single
// slice; the carry lives in a flop between cycles. Result and flags are only
// written on the completing edge so they stay stable for the whole next run.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one result bit per edge, WIDTH edges
// DONE  | done pulse cycle; a new start is accepted here back-to-back
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    alu_state_e       state;
    alu_op_e          op_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;

    logic             slice_b;
    logic             slice_z;
    logic             slice_cout;
    logic [WIDTH-1:0] res_next;

    assign slice_b = (op_r == OP_SUB) ? ~b_sr[0] : b_sr[0];

    alu_bit_slice u_slice (
        .a    (a_sr[0]),
        .b    (slice_b),
        .cin  (carry),
        .s_op (op_r),
        .z    (slice_z),
        .cout (slice_cout)
    );

    // Shift the fresh result bit in at the MSB end; written this way so
    // WIDTH=1 needs no special case.
    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = slice_z;
    end

    // Controller, datapath registers and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_r   <= OP_AND;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            z      <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        op_r  <= alu_op_e'(op);
                        cnt   <= '0;
                        // SUB is a + ~b + 1, so its carry is seeded with 1.
                        case (alu_op_e'(op))
                            OP_ADD:  carry <= cin;
                            OP_SUB:  carry <= 1'b1;
                            default: carry <= 1'b0;
                        endcase
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= slice_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here.
                        z     <= res_next;
                        cout  <= is_arith(op_r) ? slice_cout : 1'b0;
                        zero  <= (res_next == '0);
                        ovf   <= is_arith(op_r) ? (carry ^ slice_cout) : 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
